load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter WaitLimit, default 15, max ACCESS cycles without MemAck before bus fault (legal 1..255).
REQ-002 SHALL provide CLK  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL provide RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide Start  input  1  request strobe, sampled only while Busy=0.
REQ-005 SHALL provide Addr  input  32  effective address (ALU Result).
REQ-006 SHALL provide StoreData  input  32  rs2 value for stores.
REQ-007 SHALL provide MemOp  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL provide IsStore  input  1  1=store, 0=load.
REQ-009 SHALL provide Busy  output  1  transaction in progress.
REQ-010 SHALL provide Done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide LoadData  output  32  extended load result, valid with Done, held until next load Done.
REQ-012 SHALL provide Fault  output  1  misaligned/illegal/timeout flag, valid with Done.
REQ-013 SHALL provide MemReq  output  1, MemWe  output  1, MemAddr  output  32, MemWData  output  32, MemByteEn  output  4.
REQ-014 SHALL provide MemRData  input  32  and  MemAck  input  1.

Function
REQ-015 SHALL implement FSM IDLE, ACCESS, FINISH; Busy=1 in ACCESS and FINISH.
REQ-016 IDLE with Start=1 SHALL register Addr, StoreData, MemOp, IsStore and enter ACCESS next cycle.
REQ-017 Illegal op (loads 011/110/111; stores with MemOp other than 000/001/010) SHALL enter FINISH directly with Fault=1, no MemReq.
REQ-018 In ACCESS: MemReq=1, MemWe=IsStore, MemAddr={Addr[31:2],00}, all held stable for the whole state.
REQ-019 MemByteEn: byte 0001<<Addr[1:0]; half 0011<<{Addr[1],0}; word 1111; loads drive the same lanes.
REQ-020 MemWData: byte replicated x4, half replicated x2, word unchanged.
REQ-021 MemAck=1 in ACCESS SHALL move to FINISH; loads register selected lane, sign-extend B/H, zero-extend BU/HU; stores leave LoadData unchanged.
REQ-022 Wait counter SHALL clear on ACCESS entry and increment per ACCESS cycle without MemAck; at WaitLimit-1 with no ack, go FINISH with Fault=1.
REQ-023 MemAck in the same cycle as counter limit SHALL win (normal completion, Fault=0).
REQ-024 FINISH SHALL pulse Done for exactly one cycle and return to IDLE; Start in FINISH ignored.
REQ-025 Latency: Start at cycle 0, MemAck at cycle k>=1 -> Done at cycle k+1; zero-wait memory -> Done at cycle 2.
REQ-026 MemAck outside ACCESS SHALL be ignored.

Reset
REQ-027 RST at a clock edge SHALL force IDLE, counter 0, LoadData 0, Busy/Done/Fault/MemReq/MemWe 0, MemByteEn 0, MemAddr/MemWData 0.
REQ-028 Reset mid-ACCESS SHALL abort with MemReq low from the following cycle and no Done.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: H/HU at Addr[0]=1 or W at Addr[1:0]!=00 -> FINISH with Fault=1 at cycle 1, no MemReq.
REQ-030 Macro undefined: no misalign fault; H uses Addr[1] only, W ignores Addr[1:0].

Verification
REQ-031 LB Addr=0x1003, MemRData=0x80FF1234, ack at cycle 1 -> MemByteEn=1000, MemAddr=0x1000, Done at cycle 2, LoadData=0xFFFFFF80.
REQ-032 LHU Addr=0x1002, MemRData=0x80FF1234 -> MemByteEn=1100, LoadData=0x000080FF, Fault=0.
REQ-033 SB Addr=0x2001, StoreData=0x000000AB -> MemWe=1, MemByteEn=0010, MemWData=0xABABABAB, LoadData unchanged.
REQ-034 LW, WaitLimit=15, MemAck never -> MemReq cycles 1..15, Done and Fault=1 at cycle 16.
REQ-035 LW Addr=0x1002 -> with macro: Fault=1, Done at cycle 1, MemReq never high; without macro: MemAddr=0x1000, MemByteEn=1111.
REQ-036 RST asserted at cycle 3 of a stalled LW -> MemReq=0 from cycle 4, Done never pulses, next Start accepted normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store sequencer with lane steering, extension and bus timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of truncating the address.
module load_store_unit #(
    parameter int WaitLimit = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    input  logic [2:0]  MemOp,
    input  logic        IsStore,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic        Fault,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]  state;
    logic [31:0] addr_q, sdata_q, load_q;
    logic [2:0]  op_q;
    logic        store_q, fault_q;
    logic [7:0]  wait_cnt;
    logic        illegal, misalign, at_limit, access;
    logic [3:0]  byte_en;
    logic [31:0] wdata, ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        illegal   = IsStore ? (MemOp[2] | (MemOp[1:0] == 2'b11)) : ((MemOp == 3'b011) | (MemOp[2:1] == 2'b11));
`ifdef LSU_MISALIGN_TRAP_EN
        misalign  = ((MemOp[1:0] == 2'b01) & Addr[0]) | ((MemOp[1:0] == 2'b10) & (|Addr[1:0]));
`else
        misalign  = 1'b0;
`endif
        at_limit  = wait_cnt == 8'(WaitLimit - 1);
        access    = state == ACCESS;
        byte_en   = op_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                    op_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
        wdata     = op_q[1:0] == 2'b00 ? {4{sdata_q[7:0]}} :
                    op_q[1:0] == 2'b01 ? {2{sdata_q[15:0]}} : sdata_q;
        byte_lane = MemRData[{addr_q[1:0], 3'b000} +: 8];
        half_lane = MemRData[{addr_q[1], 4'b0000} +: 16];
        // funct3 bit 2 marks the unsigned variants
        ext       = op_q[1:0] == 2'b00 ? {{24{~op_q[2] & byte_lane[7]}}, byte_lane} :
                    op_q[1:0] == 2'b01 ? {{16{~op_q[2] & half_lane[15]}}, half_lane} : MemRData;
    end

    assign Busy      = state != IDLE;
    assign Done      = state == FINISH;
    assign Fault     = Done & fault_q;
    assign LoadData  = load_q;
    assign MemReq    = access;
    assign MemWe     = access & store_q;
    assign MemAddr   = access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign MemWData  = access ? wdata : 32'h0;
    assign MemByteEn = access ? byte_en : 4'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            sdata_q  <= 32'h0;
            op_q     <= 3'h0;
            store_q  <= 1'b0;
            fault_q  <= 1'b0;
            wait_cnt <= 8'h0;
            load_q   <= 32'h0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    addr_q   <= Addr;
                    sdata_q  <= StoreData;
                    op_q     <= MemOp;
                    store_q  <= IsStore;
                    wait_cnt <= 8'h0;
                    fault_q  <= illegal | misalign;
                    state    <= (illegal | misalign) ? FINISH : ACCESS;
                end
                ACCESS: if (MemAck) begin
                    state   <= FINISH;
                    fault_q <= 1'b0;
                    if (!store_q) load_q <= ext;
                end else if (at_limit) begin
                    state   <= FINISH;
                    fault_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'h1;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
